// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage feeding the IF/ID register
//
// Owns the fetch PC, requests instruction words over a req/ready handshake and
// presents PC/instruction/valid to the IF/ID register. A one-entry skid buffer
// catches the word returned while IF/ID is stalled, and a drain state lets an
// in-flight request complete (and be thrown away) after a redirect.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   stall             IF/ID cannot accept; presented outputs must hold
//   branchFlag        redirect pulse from ID
//   branchTarget      redirect address (low two bits ignored)
//   memReq/memAddr    fetch request and address (address stable while requesting)
//   memReady/memData  request accepted and instruction word valid this cycle
//   ifPC/ifInst       presented PC and instruction
//   ifValid           ifPC/ifInst hold a real instruction

module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branchFlag,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memReady,
    input  logic [INST_WIDTH-1:0] memData,
    output logic [ADDR_WIDTH-1:0] ifPC,
    output logic [INST_WIDTH-1:0] ifInst,
    output logic                  ifValid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [ADDR_WIDTH-1:0]   pend_pc;
    logic [ADDR_WIDTH-1:0]   buf_pc;
    logic [INST_WIDTH-1:0]   buf_inst;
    logic [ADDR_WIDTH-1:0]   target;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic                    slot_free;

    // Instructions are word aligned; the low two address bits are dropped.
    assign target    = branchTarget & ~ADDR_WIDTH'(3);
    assign next_pc   = fetch_pc + ADDR_WIDTH'(PC_STEP);
    assign slot_free = !ifValid || !stall;

    // A request, once raised, stays up until accepted: DRAIN keeps presenting
    // the abandoned address so the memory side sees a clean handshake.
    assign memReq  = (state == S_FETCH) || (state == S_DRAIN);
    assign memAddr = (state == S_DRAIN) ? pend_pc : fetch_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_FETCH;
            S_FETCH: begin
                if (branchFlag) begin
                    next_state = memReady ? S_FETCH : S_DRAIN;
                end else if (memReady && !slot_free) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branchFlag || !stall) begin
                    next_state = S_FETCH;
                end
            end
            // Once the abandoned request completes, fetching resumes at the
            // most recent redirect target held in fetch_pc.
            S_DRAIN: begin
                if (memReady) begin
                    next_state = S_FETCH;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            buf_pc   <= '0;
            buf_inst <= '0;
            ifPC     <= '0;
            ifInst   <= '0;
            ifValid  <= 1'b0;
        end else if (branchFlag) begin
            // Redirect wins over stall and memReady: kill the presented slot,
            // forget the skid buffer and retarget the fetch PC.
            ifPC     <= '0;
            ifInst   <= '0;
            ifValid  <= 1'b0;
            fetch_pc <= target;
            if (state == S_FETCH && !memReady) begin
                pend_pc <= fetch_pc;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (memReady) begin
                        fetch_pc <= next_pc;
                        if (slot_free) begin
                            ifPC    <= fetch_pc;
                            ifInst  <= memData;
                            ifValid <= 1'b1;
                        end else begin
                            buf_pc   <= fetch_pc;
                            buf_inst <= memData;
                        end
                    end else if (slot_free) begin
                        ifPC    <= '0;
                        ifInst  <= '0;
                        ifValid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifPC    <= buf_pc;
                        ifInst  <= buf_inst;
                        ifValid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed scoreboard bench for inst_fetch
module tb_inst_fetch;

    localparam logic [31:0] MAGIC = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchFlag;
    logic [31:0] branchTarget;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic [31:0] memData;
    logic [31:0] ifPC;
    logic [31:0] ifInst;
    logic        ifValid;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branchFlag   (branchFlag),
        .branchTarget (branchTarget),
        .memReq       (memReq),
        .memAddr      (memAddr),
        .memReady     (memReady),
        .memData      (memData),
        .ifPC         (ifPC),
        .ifInst       (ifInst),
        .ifValid      (ifValid)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is derived from its own address.
    assign memData = memAddr ^ MAGIC;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back(pc);
    endtask

    // Monitor: an instruction is consumed by IF/ID on an edge where ifValid=1
    // and stall=0; sampled on the falling edge, inputs change just after rise.
    always @(negedge clk) begin
        if (rst && ifValid && !stall) begin
            logic [31:0] pc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_inst: got pc %08h expected none", ifPC);
            end else begin
                pc = exp_q.pop_front();
                if (ifPC !== pc || ifInst !== (pc ^ MAGIC)) begin
                    bad++;
                    $display("FAIL sb_inst: got pc %08h inst %08h expected pc %08h inst %08h",
                             ifPC, ifInst, pc, pc ^ MAGIC);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; branchFlag = 1'b0; branchTarget = '0; memReady = 1'b1;
        step(); step();
        chk("rst_valid", {31'd0, ifValid}, 32'd0);
        chk("rst_pc", ifPC, 32'd0);
        chk("rst_inst", ifInst, 32'd0);
        chk("rst_req", {31'd0, memReq}, 32'd0);

        // Streaming from reset, then a 3-cycle stall at PC 8.
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        expect_pc(32'hC); expect_pc(32'h10);
        rst = 1'b1;
        step();                                   // edge 1: IDLE -> FETCH
        chk("first_req", {31'd0, memReq}, 32'd1);
        chk("first_addr", memAddr, 32'h0);
        chk("first_valid", {31'd0, ifValid}, 32'd0);
        step();                                   // edge 2
        chk("lat_valid", {31'd0, ifValid}, 32'd1);
        chk("lat_pc", ifPC, 32'h0);
        step(); step();                           // edges 3, 4
        chk("pc8", ifPC, 32'h8);
        stall = 1'b1;
        step();                                   // edge 5: PC 12 into skid buffer
        chk("hold_req", {31'd0, memReq}, 32'd0);
        chk("hold_pc", ifPC, 32'h8);
        step(); step();                           // edges 6, 7
        chk("hold_pc2", ifPC, 32'h8);
        chk("hold_inst2", ifInst, 32'h8 ^ MAGIC);
        stall = 1'b0;
        step();                                   // edge 8: buffer -> outputs
        chk("skid_pc", ifPC, 32'hC);
        chk("resume_addr", memAddr, 32'h10);
        step(); step();                           // edges 9, 10 (PC 20 shown)
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ifValid}, 32'd0);
        chk("midrst_pc", ifPC, 32'd0);
        chk("midrst_req", {31'd0, memReq}, 32'd0);
        step();

        // Memory wait at PC 4, then redirect while 0x10 is outstanding.
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        expect_pc(32'hC); expect_pc(32'h40);
        rst = 1'b1;
        step(); step();                           // edges 1, 2
        memReady = 1'b0;
        step();                                   // edge 3: bubble
        chk("wait_addr", memAddr, 32'h4);
        chk("wait_req", {31'd0, memReq}, 32'd1);
        chk("bubble_valid", {31'd0, ifValid}, 32'd0);
        chk("bubble_inst", ifInst, 32'd0);
        step();                                   // edge 4
        chk("wait_addr2", memAddr, 32'h4);
        memReady = 1'b1;
        step();                                   // edge 5: PC 4 shown
        chk("pc4", ifPC, 32'h4);
        step(); step();                           // edges 6, 7
        memReady = 1'b0;
        step();                                   // edge 8: request 0x10 pending
        branchFlag = 1'b1; branchTarget = 32'h40;
        step();                                   // edge 9: -> DRAIN
        branchFlag = 1'b0;
        chk("drain_addr", memAddr, 32'h10);
        chk("drain_req", {31'd0, memReq}, 32'd1);
        chk("drain_valid", {31'd0, ifValid}, 32'd0);
        step();                                   // edge 10
        chk("drain_addr2", memAddr, 32'h10);
        memReady = 1'b1;
        step();                                   // edge 11: 0x10 data dropped
        chk("redir_addr", memAddr, 32'h40);
        chk("redir_valid", {31'd0, ifValid}, 32'd0);
        step();                                   // edge 12: 0x40 shown
        chk("redir_pc", ifPC, 32'h40);

        // Branch while HOLD under stall; PC 0x44 is discarded by the branch.
        step();                                   // edge 13: 0x44 shown
        stall = 1'b1;
        step();                                   // edge 14: 0x48 buffered
        chk("hold2_req", {31'd0, memReq}, 32'd0);
        branchFlag = 1'b1; branchTarget = 32'h103;
        step();                                   // edge 15
        branchFlag = 1'b0; stall = 1'b0;
        chk("hbr_valid", {31'd0, ifValid}, 32'd0);
        chk("hbr_addr", memAddr, 32'h100);
        expect_pc(32'h100); expect_pc(32'h104);
        step(); step();                           // edges 16, 17

        // Wrap of the fetch PC at the top of the address space.
        branchFlag = 1'b1; branchTarget = 32'hFFFF_FFFC;
        step();                                   // edge 18
        branchFlag = 1'b0;
        chk("wrap_addr0", memAddr, 32'hFFFF_FFFC);
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        step();                                   // edge 19
        chk("wrap_addr", memAddr, 32'h0);
        step();                                   // edge 20
        memReady = 1'b0;
        step(); step(); step();

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly upstream of the IF/ID pipeline register: owns the fetch PC, requests instructions from instruction memory over a req/ready handshake and presents `ifPC`/`ifInst`/`ifValid` to IF/ID.
- Handles downstream stall, branch redirect/flush and variable-latency memory.
- A one-entry skid buffer and a drain state mean no instruction is lost or duplicated.

Parameters:
- ADDR_WIDTH, 32, width of `ifPC`/`memAddr`/`branchTarget` (INST_ADDR_BUS).
- INST_WIDTH, 32, width of `ifInst`/`memData` (INST_BUS).
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- stall  in  1  IF/ID cannot accept; output registers must hold.
- branchFlag  in  1  redirect request from ID; one-cycle pulse.
- branchTarget  in  ADDR_WIDTH  redirect address; bits [1:0] forced to 0 internally.
- memReq  out  1  fetch request.
- memAddr  out  ADDR_WIDTH  fetch address; stable while memReq=1.
- memReady  in  1  memData valid and request accepted this cycle.
- memData  in  INST_WIDTH  instruction word.
- ifPC  out  ADDR_WIDTH  PC of presented instruction.
- ifInst  out  INST_WIDTH  presented instruction.
- ifValid  out  1  ifPC/ifInst hold a real instruction.

Behaviour:
- States: IDLE, FETCH, HOLD, DRAIN.
  - memReq=1 in FETCH and DRAIN only.
  - memAddr = fetchPC in FETCH, pendPC in DRAIN.
- Reset (async, rst=0):
  - state=IDLE; fetchPC=RESET_PC.
  - ifPC=0, ifInst=0, ifValid=0, memReq=0.
  - Skid buffer cleared.
- Reset deasserted mid-transaction: the outstanding request is abandoned; the memory side must tolerate this.
- IDLE: unconditionally moves to FETCH on the next edge. First memReq is asserted one cycle after reset release.
- Output slot free = !ifValid || !stall. Updates to ifPC/ifInst/ifValid are registered.
- FETCH, memReady=1, no branch:
  - Slot free: ifPC<=fetchPC, ifInst<=memData, ifValid<=1, fetchPC<=fetchPC+PC_STEP; stay in FETCH.
  - Slot busy: bufPC/bufInst<=fetchPC/memData, fetchPC+=PC_STEP; go to HOLD.
- FETCH, memReady=0, no branch: if slot free, ifValid<=0 and ifPC/ifInst<=0 (bubble); else hold outputs.
- HOLD: memReq=0. When stall=0: outputs<=buffer, ifValid<=1; go to FETCH.
- Branch (branchFlag=1) beats stall and memReady:
  - ifValid<=0, ifPC/ifInst<=0; buffer discarded.
  - FETCH with memReady=1: data discarded; fetchPC<=target; stay in FETCH.
  - FETCH with memReady=0: pendPC<=fetchPC, fetchPC<=target; go to DRAIN. A request is never retracted.
  - HOLD: fetchPC<=target; go to FETCH.
  - DRAIN: fetchPC<=target (latest target wins); stay in DRAIN.
  - IDLE: fetchPC<=target.
- DRAIN: on memReady, discard memData; go to FETCH at fetchPC. Outputs stay invalid meanwhile.
- Arithmetic: fetchPC+PC_STEP wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
- Ordering: each PC is presented at most once with ifValid=1, in program order, except where a branch discards it.
- Latency: with memReady tied 1 and stall=0, the first instruction is valid 2 cycles after reset release, then one per cycle.

Test Plan:
- Reset release, memReady=1, memData=PC-derived, stall=0 -> ifValid rises 2nd edge after release; ifPC 0,4,8,12 on consecutive cycles; rst=0 mid-run clears all outputs immediately.
- Stall for 3 cycles while ifPC=8 valid and memReady=1 -> ifPC/ifInst hold 8; PC 12 goes to the skid buffer and memReq drops; after stall falls, ifPC=12 then 16; no PC skipped or repeated.
- memReady low 2 cycles at PC 4 -> memAddr stays 4 with memReq=1; ifValid=0 with ifInst=0 during the bubble; PC 4 presented when ready.
- Redirect: branchFlag with target 0x40 while request for 0x10 is pending (memReady=0) -> DRAIN; memAddr stays 0x10 until ready; 0x10 data discarded; next memAddr=0x40; ifValid=0 until 0x40 is presented.
- Branch during HOLD with stall=1, target 0x103 -> buffer dropped; ifValid=0 next cycle; fetch at 0x100.
- fetchPC=0xFFFFFFFC, memReady=1 -> next memAddr=0x00000000.
